// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer driving the DDS Freq_KW/Ampl_KW control words.
// Amplitude is ramped in and out around every sweep so start, end and abort are glitch-free.
//   state     | meaning
//   IDLE      | amplitude zero, frequency held, waiting for start
//   RAMP_UP   | amplitude rising toward target at the first point
//   SWEEP     | dwell down-counter running, frequency stepping
//   RAMP_DOWN | amplitude falling, frequency frozen
//   DONE      | one-cycle done pulse
module dds_sweep_ctrl #(
  parameter int FKW_WIDTH   = 28,
  parameter int DAC_WIDTH   = 12,
  parameter int DWELL_WIDTH = 16,
  parameter int AMPL_STEP   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FKW_WIDTH-1:0]   f_start,
  input  logic [FKW_WIDTH-1:0]   f_step,
  input  logic [FKW_WIDTH-1:0]   f_stop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [DAC_WIDTH-1:0]   ampl_target,
  input  logic                   mode,
  output logic [FKW_WIDTH-1:0]   Freq_KW,
  output logic [DAC_WIDTH-1:0]   Ampl_KW,
  output logic                   busy,
  output logic                   step_stb,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP_UP, S_SWEEP, S_RAMP_DOWN, S_DONE
  } state_t;

  localparam logic [31:0]          STEP_EXT = AMPL_STEP;
  localparam logic [DAC_WIDTH-1:0] STEP_W   = DAC_WIDTH'(AMPL_STEP);

  state_t                 state_q, state_d;
  logic [FKW_WIDTH-1:0]   freq_q, freq_d;
  logic [FKW_WIDTH-1:0]   f_start_q, f_start_d, f_step_q, f_step_d, f_stop_q, f_stop_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic [DAC_WIDTH-1:0]   ampl_q, ampl_d, target_q, target_d;
  logic                   mode_q, mode_d;
  logic                   step_stb_q, step_stb_d, done_q, done_d;

  logic [FKW_WIDTH:0]     freq_next;
  logic [31:0]            ampl_ext, target_ext;

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    ampl_d     = ampl_q;
    cnt_d      = cnt_q;
    f_start_d  = f_start_q;
    f_step_d   = f_step_q;
    f_stop_d   = f_stop_q;
    dwell_d    = dwell_q;
    target_d   = target_q;
    mode_d     = mode_q;
    step_stb_d = 1'b0;
    done_d     = 1'b0;
    // One extra bit so a step past the top of the word range compares as out of bounds.
    freq_next  = {1'b0, freq_q} + {1'b0, f_step_q};
    ampl_ext   = 32'(ampl_q);
    target_ext = 32'(target_q);

    case (state_q)
      S_IDLE: begin
        ampl_d = '0;
        if (start && !abort) begin
          f_start_d = f_start;
          f_step_d  = f_step;
          f_stop_d  = f_stop;
          dwell_d   = dwell;
          target_d  = ampl_target;
          mode_d    = mode;
          freq_d    = f_start;
          state_d   = S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (abort) begin
          state_d = S_RAMP_DOWN;
        end else if (ampl_ext + STEP_EXT >= target_ext) begin
          ampl_d  = target_q;
          cnt_d   = dwell_q;
          state_d = S_SWEEP;
        end else begin
          ampl_d = ampl_q + STEP_W;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          state_d = S_RAMP_DOWN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (f_step_q != '0 && freq_next <= {1'b0, f_stop_q}) begin
          freq_d     = freq_next[FKW_WIDTH-1:0];
          step_stb_d = 1'b1;
          cnt_d      = dwell_q;
        end else if (mode_q && f_step_q != '0) begin
          freq_d     = f_start_q;
          step_stb_d = 1'b1;
          cnt_d      = dwell_q;
        end else begin
          state_d = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (ampl_ext <= STEP_EXT) begin
          ampl_d  = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ampl_d = ampl_q - STEP_W;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      freq_q     <= '0;
      ampl_q     <= '0;
      cnt_q      <= '0;
      f_start_q  <= '0;
      f_step_q   <= '0;
      f_stop_q   <= '0;
      dwell_q    <= '0;
      target_q   <= '0;
      mode_q     <= 1'b0;
      step_stb_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      ampl_q     <= ampl_d;
      cnt_q      <= cnt_d;
      f_start_q  <= f_start_d;
      f_step_q   <= f_step_d;
      f_stop_q   <= f_stop_d;
      dwell_q    <= dwell_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      step_stb_q <= step_stb_d;
      done_q     <= done_d;
    end
  end

  assign Freq_KW  = freq_q;
  assign Ampl_KW  = ampl_q;
  assign step_stb = step_stb_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a trace model builds each sweep's per-cycle outputs
// from ramp counts and the frequency point list; a negedge monitor pops and compares.
module tb_dds_sweep_ctrl;

  localparam int STEP = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort, mode;
  logic [27:0] f_start, f_step, f_stop;
  logic [15:0] dwell;
  logic [11:0] ampl_target;
  logic [27:0] Freq_KW;
  logic [11:0] Ampl_KW;
  logic        busy, step_stb, done;

  dds_sweep_ctrl #(
    .FKW_WIDTH(28), .DAC_WIDTH(12), .DWELL_WIDTH(16), .AMPL_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .f_stop(f_stop), .dwell(dwell),
    .ampl_target(ampl_target), .mode(mode),
    .Freq_KW(Freq_KW), .Ampl_KW(Ampl_KW), .busy(busy),
    .step_stb(step_stb), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] freq;
    logic [11:0] ampl;
    logic        stb;
    logic        done;
    logic        busy;
  } exp_t;

  typedef struct {
    logic [27:0] fs, fp, fe;
    logic [15:0] dw;
    logic [11:0] tg;
    logic        md;
  } cfg_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [27:0] last_freq = '0;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (Freq_KW !== mon_e.freq || Ampl_KW !== mon_e.ampl || step_stb !== mon_e.stb ||
          done !== mon_e.done || busy !== mon_e.busy) begin
        errors++;
        $display("FAIL outputs cyc %0d: got freq=%0h ampl=%0d stb=%0b done=%0b busy=%0b, expected freq=%0h ampl=%0d stb=%0b done=%0b busy=%0b",
                 cyc, Freq_KW, Ampl_KW, step_stb, done, busy,
                 mon_e.freq, mon_e.ampl, mon_e.stb, mon_e.done, mon_e.busy);
      end
    end
  end

  // Builds the expected outputs from the accept cycle (index 0) to the first idle cycle
  // after done; ab/rs are the cycle indices at which abort/rst are driven (0 = never).
  task automatic gen_sweep(input cfg_t c, input int ab, input int rs, output int len);
    longint pts[$];
    longint nx;
    exp_t   tr[$];
    exp_t   e;
    int     rr, n, a;
    bit     stop_now;
    pts.push_back(longint'(c.fs));
    if (c.fp != 0) begin
      nx = longint'(c.fs) + longint'(c.fp);
      while (nx <= longint'(c.fe) && pts.size() < 64) begin
        pts.push_back(nx);
        nx += longint'(c.fp);
      end
    end
    e = '{freq: last_freq, ampl: 12'd0, stb: 1'b0, done: 1'b0, busy: 1'b0};
    tr.push_back(e);
    rr = (c.tg == 0) ? 1 : (int'(c.tg) + STEP - 1) / STEP;
    stop_now = 1'b0;
    e = '{freq: c.fs, ampl: 12'd0, stb: 1'b0, done: 1'b0, busy: 1'b1};
    for (int k = 0; k < rr && !stop_now; k++) begin
      e.ampl = 12'(k * STEP);
      tr.push_back(e);
      if (tr.size() - 1 == ab) stop_now = 1'b1;
    end
    n = 0;
    while (!stop_now) begin
      for (int d = 0; d <= int'(c.dw) && !stop_now; d++) begin
        e.freq = 28'(pts[n % pts.size()]);
        e.ampl = c.tg;
        e.stb  = (n > 0 && d == 0);
        tr.push_back(e);
        if (tr.size() - 1 == ab) stop_now = 1'b1;
      end
      n++;
      if (!(c.md && c.fp != 0) && n == pts.size()) stop_now = 1'b1;
      if (tr.size() > 4000) stop_now = 1'b1;
    end
    e.stb = 1'b0;
    a = int'(e.ampl);
    forever begin
      e.ampl = 12'(a);
      tr.push_back(e);
      if (a <= STEP) break;
      a -= STEP;
    end
    e.ampl = 12'd0;
    e.done = 1'b1;
    tr.push_back(e);
    e.done = 1'b0;
    e.busy = 1'b0;
    tr.push_back(e);
    if (rs > 0 && rs < tr.size()) begin
      while (tr.size() > rs + 1) void'(tr.pop_back());
      tr.push_back('{freq: 28'd0, ampl: 12'd0, stb: 1'b0, done: 1'b0, busy: 1'b0});
      last_freq = '0;
    end else begin
      last_freq = e.freq;
    end
    len = tr.size();
    foreach (tr[i]) exp_q.push_back(tr[i]);
  endtask

  task automatic run(input cfg_t c, input int ab, input int rs, input bit noise);
    int len;
    @(posedge clk); #2;
    rst = 1'b0; abort = 1'b0; start = 1'b1;
    f_start = c.fs; f_step = c.fp; f_stop = c.fe;
    dwell = c.dw; ampl_target = c.tg; mode = c.md;
    gen_sweep(c, ab, rs, len);
    for (int t = 1; t < len; t++) begin
      @(posedge clk); #2;
      start = (noise && t < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (t == ab);
      rst   = (t == rs);
      if (noise) begin
        f_step      = 28'($urandom_range(0, 5000));
        f_start     = 28'($urandom);
        f_stop      = 28'($urandom);
        dwell       = 16'($urandom_range(0, 9));
        ampl_target = 12'($urandom);
        mode        = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic idle(input int n, input bit junk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      rst = 1'b0; start = junk; abort = junk;
      exp_q.push_back('{freq: last_freq, ampl: 12'd0, stb: 1'b0, done: 1'b0, busy: 1'b0});
    end
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    int   np;
    c.dw = 16'($urandom_range(0, 3));
    c.tg = 12'($urandom_range(0, 400));
    c.md = 1'b0;
    if ($urandom_range(0, 7) == 0) begin
      c.fs = 28'hFFFF000 + 28'($urandom_range(0, 28'hF00));
      c.fp = 28'($urandom_range(28'h200, 28'h800));
      c.fe = 28'hFFFFFFF;
    end else begin
      c.fs = 28'($urandom_range(1000, 28'h7FFFFFF));
      c.fp = ($urandom_range(0, 5) == 0) ? 28'd0 : 28'($urandom_range(1, 4000));
      np   = $urandom_range(1, 5);
      if ($urandom_range(0, 6) == 0)
        c.fe = c.fs - 28'($urandom_range(1, 900));
      else
        c.fe = c.fs + c.fp * 28'(np - 1) +
               28'($urandom_range(0, (c.fp == 0) ? 100 : int'(c.fp) - 1));
    end
    return c;
  endfunction

  cfg_t c1, c2, c3, c4, cr;
  int   ab, rs;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    f_start = '0; f_step = '0; f_stop = '0; dwell = '0; ampl_target = '0;
    @(posedge clk);
    idle(3, 1'b0);

    c1 = '{fs: 28'd1000, fp: 28'd500, fe: 28'd2000, dw: 16'd3, tg: 12'd100, md: 1'b0};
    run(c1, 0, 0, 1'b0);
    idle(2, 1'b0);

    c2 = '{fs: 28'hFFFFF00, fp: 28'h200, fe: 28'hFFFFFFF, dw: 16'd2, tg: 12'd100, md: 1'b0};
    run(c2, 0, 0, 1'b0);
    idle(1, 1'b0);

    c3 = '{fs: 28'd10, fp: 28'd10, fe: 28'd30, dw: 16'd0, tg: 12'd64, md: 1'b1};
    run(c3, 12, 0, 1'b0);
    idle(1, 1'b0);

    c4 = '{fs: 28'd5000, fp: 28'd100, fe: 28'd5300, dw: 16'd1, tg: 12'd200, md: 1'b0};
    run(c4, 2, 0, 1'b0);
    idle(1, 1'b0);

    run(c1, 0, 0, 1'b1);
    idle(3, 1'b1);

    run(c1, 0, 9, 1'b0);
    idle(1, 1'b0);
    run(c1, 0, 0, 1'b0);
    idle(1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      cr = rand_cfg();
      cr.md = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      rs = (ab == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0;
      if (cr.md && cr.fp != 0 && ab == 0 && rs == 0) ab = $urandom_range(1, 40);
      run(cr, ab, rs, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    idle(2, 1'b0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
